l2_l3_req_arbiter: RTL and testbench
====================================

Name: l2_l3_req_arbiter

Overview:
Upstream request stage in front of the L3 slice.
- Accepts read/write requests from N_PORTS L2 caches into per-port request FIFOs.
- Picks one request at a time by round-robin and issues it to the L3 slice with a single-transaction handshake.
- Captures the slice response and returns it to the originating L2 port; exactly one transaction is outstanding at any time.

Parameters:
N_PORTS, 4, number of L2 requesters (>=2, power of two)
FIFO_DEPTH, 2, entries per port request FIFO (power of two)
ADDR_W, 64, request address width
DATA_W, 64, data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
l2_req_valid_i  in  N_PORTS  per-port request valid
l2_req_ready_o  out  N_PORTS  per-port FIFO not full
l2_req_addr_i  in  N_PORTS*ADDR_W  packed per-port address, port p at [p*ADDR_W +: ADDR_W]
l2_req_write_i  in  N_PORTS  per-port write flag
l2_req_wdata_i  in  N_PORTS*DATA_W  packed per-port write data
l2_resp_valid_o  out  N_PORTS  one-hot response valid
l2_resp_ready_i  in  N_PORTS  per-port response accept
l2_resp_rdata_o  out  DATA_W  response data, shared by all ports
l3_req_valid_o  out  1  request to slice
l3_req_addr_o  out  ADDR_W  request address
l3_req_write_o  out  1  request write flag
l3_req_wdata_o  out  DATA_W  request write data
l3_resp_ready_o  out  1  slice accept enable; equals l3_req_valid_o
l3_resp_valid_i  in  1  slice response valid
l3_resp_rdata_i  in  DATA_W  slice read data; 0 for writes

Behaviour:
Reset values:
- All outputs are 0.
- FIFOs are empty and the round-robin pointer is 0.
- State is IDLE and the captured winner index is 0.

Request enqueue:
- l2_req_ready_o[p] = !full[p].
- Push on l2_req_valid_i[p] && l2_req_ready_o[p].
- There is no bypass: ready depends on occupancy at cycle start, so a same-cycle pop does not free space for a same-cycle push.

FSM:
- IDLE: if any FIFO is non-empty, select the winner as the first non-empty port searching from rr_ptr upward, with wrap-around. On the next edge, pop the winner's head, register it onto the l3_req_* outputs, set l3_req_valid_o = l3_resp_ready_o = 1, store the winner index, and go to ISSUE.
- ISSUE: outputs are held for exactly one cycle, during which the slice samples them. On the next edge, clear l3_req_valid_o/l3_resp_ready_o and go to WAIT.
- WAIT: on l3_resp_valid_i, register l3_resp_rdata_i into l2_resp_rdata_o, set l2_resp_valid_o[winner], and go to RESP. Remain in WAIT indefinitely otherwise.
- RESP: hold data and valid until l2_resp_ready_i[winner]. On that edge, clear valid, set rr_ptr = winner+1 (mod N_PORTS), and go to IDLE.

Latency:
- The request is pushed at edge E0 and issued at E1.
- The slice samples it at E2 and asserts response valid in the cycle after E2.
- The response is captured at E3, so l2_resp_valid_o is high 3 cycles after the push edge (min).
- Back-to-back throughput is 1 transaction per 4 cycles when responses are accepted immediately.

Other rules:
- Writes return a response (ack, rdata = 0) exactly like reads.
- l3_resp_valid_i outside WAIT is ignored. No state change occurs and nothing is forwarded.
- Fairness: a port that just completed has lowest priority next arbitration. With all ports backlogged, grants rotate 0,1,2,3,0...
- l2_resp_ready_i of non-winner ports is ignored.
- Reset mid-operation (any state) returns immediately to the reset values. In-flight and queued requests are dropped with no response.

Decomposition:
- Shared package l3_pkg: ADDR_W/DATA_W constants, l3_req_t struct {addr, write, wdata}, arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module l3_req_fifo: single-clock FIFO of l3_req_t with push/pop/full/empty and async reset, instantiated N_PORTS times.
- The round-robin priority search stays in the top as a function.

Test Plan:
1. Single read: port 2 pushes addr 0x40 (read) and slice memory holds 0xDEAD_BEEF at that word -> l3_req_valid_o high 1 cycle after push with addr 0x40; l2_resp_valid_o = 4'b0100 with rdata 0xDEAD_BEEF 3 cycles after push.
2. Write then read: port 0 writes 0x1234 to addr 0x80, then reads 0x80 -> first response rdata 0, second response rdata 0x1234, in order.
3. Fairness: all 4 ports each push 2 requests in the same cycle with l2_resp_ready_i held 1 -> grant order 0,1,2,3,0,1,2,3; each issue 4 cycles apart.
4. FIFO full and backpressure: port 1 pushes 3 requests on consecutive cycles while the arbiter is held in RESP by l2_resp_ready_i[3]=0 -> l2_req_ready_o[1]=0 after 2 pushes and the 3rd is not accepted; the remaining entries are preserved and issued after release.
5. Spurious response: pulse l3_resp_valid_i in IDLE with rdata 0xFFFF -> no l2_resp_valid_o and state stays IDLE.
6. Reset mid-WAIT: assert rst_n=0 while in WAIT with 2 entries queued -> all outputs 0 immediately and FIFOs empty; after release, no response is produced for the dropped requests.

Source files
------------

// File: rtl/l3_pkg.sv
// Shared types for the L2-to-L3 request path: request payload and arbiter state encoding.
package l3_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } l3_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/l3_req_fifo.sv
// Single-clock request FIFO of l3_req_t; DEPTH must be a power of two (>= 2).
module l3_req_fifo
  import l3_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  l3_req_t data_i,
  input  logic    pop_i,
  output l3_req_t data_o,
  output logic    full_o,
  output logic    empty_o,
  output logic    full_nxt_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  l3_req_t     mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic logic is_full(input logic [PW:0] w, input logic [PW:0] r);
    return (w[PW] != r[PW]) && (w[PW-1:0] == r[PW-1:0]);
  endfunction

  // Next pointer values
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) begin
      wr_d = wr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (pop_i) begin
      rd_d = rd_q + {{PW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_i) begin
        mem_q[wr_q[PW-1:0]] <= data_i;
      end
    end
  end

  assign data_o     = mem_q[rd_q[PW-1:0]];
  assign full_o     = is_full(wr_q, rd_q);
  assign empty_o    = (wr_q == rd_q);
  assign full_nxt_o = is_full(wr_d, rd_d);

endmodule

// File: rtl/l2_l3_req_arbiter.sv
// Round-robin arbiter in front of an L3 slice: per-port request FIFOs, one outstanding
// transaction, response routed back to the granted L2 port.
module l2_l3_req_arbiter
  import l3_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = l3_pkg::ADDR_W,
  parameter int DATA_W     = l3_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          l2_req_valid_i,
  output logic [N_PORTS-1:0]          l2_req_ready_o,
  input  logic [N_PORTS*ADDR_W-1:0]   l2_req_addr_i,
  input  logic [N_PORTS-1:0]          l2_req_write_i,
  input  logic [N_PORTS*DATA_W-1:0]   l2_req_wdata_i,
  output logic [N_PORTS-1:0]          l2_resp_valid_o,
  input  logic [N_PORTS-1:0]          l2_resp_ready_i,
  output logic [DATA_W-1:0]           l2_resp_rdata_o,
  output logic                        l3_req_valid_o,
  output logic [ADDR_W-1:0]           l3_req_addr_o,
  output logic                        l3_req_write_o,
  output logic [DATA_W-1:0]           l3_req_wdata_o,
  output logic                        l3_resp_ready_o,
  input  logic                        l3_resp_valid_i,
  input  logic [DATA_W-1:0]           l3_resp_rdata_i
);

  localparam int                 IDX_W   = $clog2(N_PORTS);
  localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);
  localparam logic [N_PORTS-1:0] OH_ONE  = N_PORTS'(1);

  l3_req_t            req_in_s [N_PORTS];
  l3_req_t            head_s   [N_PORTS];
  logic [N_PORTS-1:0] push_s, pop_s, full_s, empty_s, full_nxt_s;
  logic [IDX_W-1:0]   pick_s;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  l3_req_t            l3_req_q, l3_req_d;
  logic               l3_vld_q, l3_vld_d;
  logic [N_PORTS-1:0] resp_vld_q, resp_vld_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [N_PORTS-1:0] ready_q;

  // First requesting port at or after ptr, wrapping; N_PORTS is a power of two.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign req_in_s[p] = {l2_req_addr_i[p*ADDR_W +: ADDR_W], l2_req_write_i[p],
                          l2_req_wdata_i[p*DATA_W +: DATA_W]};
    assign push_s[p]   = l2_req_valid_i[p] & ready_q[p] & ~full_s[p];

    l3_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push_s[p]),
      .data_i     (req_in_s[p]),
      .pop_i      (pop_s[p]),
      .data_o     (head_s[p]),
      .full_o     (full_s[p]),
      .empty_o    (empty_s[p]),
      .full_nxt_o (full_nxt_s[p])
    );
  end

  assign pick_s = rr_pick(~empty_s, rr_q);

  // Arbitration FSM: next state, FIFO pops and next output values
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    l3_req_d   = l3_req_q;
    l3_vld_d   = 1'b0;
    resp_vld_d = resp_vld_q;
    rdata_d    = rdata_q;
    pop_s      = '0;
    case (state_q)
      IDLE: begin
        if (|(~empty_s)) begin
          pop_s[pick_s] = 1'b1;
          l3_req_d      = head_s[pick_s];
          l3_vld_d      = 1'b1;
          win_d         = pick_s;
          state_d       = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (l3_resp_valid_i) begin
          rdata_d    = l3_resp_rdata_i;
          resp_vld_d = OH_ONE << win_q;
          state_d    = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (l2_resp_ready_i[win_q]) begin
          resp_vld_d = '0;
          rr_d       = win_q + IDX_ONE;
          state_d    = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is registered from next-cycle fullness so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      l3_req_q   <= '0;
      l3_vld_q   <= 1'b0;
      resp_vld_q <= '0;
      rdata_q    <= '0;
      ready_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      l3_req_q   <= l3_req_d;
      l3_vld_q   <= l3_vld_d;
      resp_vld_q <= resp_vld_d;
      rdata_q    <= rdata_d;
      ready_q    <= ~full_nxt_s;
    end
  end

  assign l2_req_ready_o  = ready_q;
  assign l2_resp_valid_o = resp_vld_q;
  assign l2_resp_rdata_o = rdata_q;
  assign l3_req_valid_o  = l3_vld_q;
  assign l3_resp_ready_o = l3_vld_q;
  assign l3_req_addr_o   = l3_req_q.addr;
  assign l3_req_write_o  = l3_req_q.write;
  assign l3_req_wdata_o  = l3_req_q.wdata;

endmodule

// File: tb/tb_l2_l3_req_arbiter.sv
// Directed self-checking bench for l2_l3_req_arbiter with a small behavioural L3 slice.
module tb_l2_l3_req_arbiter;

  localparam int NP = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    l2_req_valid_i = '0;
  logic [NP-1:0]    l2_req_ready_o;
  logic [NP*AW-1:0] l2_req_addr_i = '0;
  logic [NP-1:0]    l2_req_write_i = '0;
  logic [NP*DW-1:0] l2_req_wdata_i = '0;
  logic [NP-1:0]    l2_resp_valid_o;
  logic [NP-1:0]    l2_resp_ready_i = '0;
  logic [DW-1:0]    l2_resp_rdata_o;
  logic             l3_req_valid_o;
  logic [AW-1:0]    l3_req_addr_o;
  logic             l3_req_write_o;
  logic [DW-1:0]    l3_req_wdata_o;
  logic             l3_resp_ready_o;
  logic             l3_resp_valid_i;
  logic [DW-1:0]    l3_resp_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  // slice model state (written only by the slice process)
  logic [63:0] mem [0:255];
  logic [63:0] iss_addr [$];
  logic        iss_wr [$];
  int          iss_cyc [$];
  int          ncnt;
  int          spur_done;
  logic        pend;
  logic [63:0] pend_data;
  // controls written only by the main process
  int          spur_cnt = 0;
  logic        slice_hold = 1'b0;

  always #5 clk = ~clk;

  l2_l3_req_arbiter #(.N_PORTS(NP), .FIFO_DEPTH(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .l2_req_valid_i  (l2_req_valid_i),
    .l2_req_ready_o  (l2_req_ready_o),
    .l2_req_addr_i   (l2_req_addr_i),
    .l2_req_write_i  (l2_req_write_i),
    .l2_req_wdata_i  (l2_req_wdata_i),
    .l2_resp_valid_o (l2_resp_valid_o),
    .l2_resp_ready_i (l2_resp_ready_i),
    .l2_resp_rdata_o (l2_resp_rdata_o),
    .l3_req_valid_o  (l3_req_valid_o),
    .l3_req_addr_o   (l3_req_addr_o),
    .l3_req_write_o  (l3_req_write_o),
    .l3_req_wdata_o  (l3_req_wdata_o),
    .l3_resp_ready_o (l3_resp_ready_o),
    .l3_resp_valid_i (l3_resp_valid_i),
    .l3_resp_rdata_i (l3_resp_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slice: samples a request while valid, answers one cycle later (reads from mem, writes ack 0).
  initial begin
    l3_resp_valid_i = 1'b0;
    l3_resp_rdata_i = '0;
    ncnt = 0;
    spur_done = 0;
    pend = 1'b0;
    pend_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[8] = 64'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      ncnt++;
      l3_resp_valid_i = 1'b0;
      l3_resp_rdata_i = '0;
      if (pend) begin
        l3_resp_valid_i = 1'b1;
        l3_resp_rdata_i = pend_data;
        pend = 1'b0;
      end else if (spur_cnt != spur_done) begin
        spur_done++;
        l3_resp_valid_i = 1'b1;
        l3_resp_rdata_i = 64'hFFFF;
      end
      if (l3_req_valid_o) begin
        iss_addr.push_back(l3_req_addr_o);
        iss_wr.push_back(l3_req_write_o);
        iss_cyc.push_back(ncnt);
        if (l3_req_write_o) begin
          mem[l3_req_addr_o[10:3]] = l3_req_wdata_o;
          pend_data = 64'h0;
        end else begin
          pend_data = mem[l3_req_addr_o[10:3]];
        end
        pend = !slice_hold;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_req(input logic [1:0] p, input logic [63:0] a, input logic w, input logic [63:0] d);
    l2_req_valid_i[p]           = 1'b1;
    l2_req_addr_i[p*AW +: AW]   = a;
    l2_req_write_i[p]           = w;
    l2_req_wdata_i[p*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    l2_req_valid_i = '0;
    l2_resp_ready_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Read with minimum latency: issue 1 cycle after push, response 3 cycles after push.
  task automatic single_read(input string tag, input logic [1:0] p, input logic [63:0] a,
                             input logic [63:0] exp);
    @(negedge clk);
    set_req(p, a, 1'b0, 64'h0);
    @(negedge clk);
    l2_req_valid_i[p] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_iss_v"}, 64'(l3_req_valid_o), 64'h1);
    check_eq({tag, "_iss_rr"}, 64'(l3_resp_ready_o), 64'h1);
    check_eq({tag, "_iss_a"}, l3_req_addr_o, a);
    check_eq({tag, "_iss_w"}, 64'(l3_req_write_o), 64'h0);
    @(negedge clk);
    check_eq({tag, "_iss_drop"}, 64'(l3_req_valid_o), 64'h0);
    check_eq({tag, "_early"}, 64'(l2_resp_valid_o), 64'h0);
    @(negedge clk);
    check_eq({tag, "_rv"}, 64'(l2_resp_valid_o), 64'(4'b0001 << p));
    check_eq({tag, "_rd"}, l2_resp_rdata_o, exp);
  endtask

  task automatic wait_resp(input string tag, input logic [3:0] ev, input logic [63:0] ed);
    for (int n = 0; n < 30 && l2_resp_valid_o == 4'b0000; n++) @(negedge clk);
    check_eq({tag, "_rv"}, 64'(l2_resp_valid_o), 64'(ev));
    check_eq({tag, "_rd"}, l2_resp_rdata_o, ed);
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [3:0] seen;

    // reset values
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(l2_req_ready_o), 64'h0);
    check_eq("rst_l3v", 64'(l3_req_valid_o), 64'h0);
    check_eq("rst_l3rr", 64'(l3_resp_ready_o), 64'h0);
    check_eq("rst_addr", l3_req_addr_o, 64'h0);
    check_eq("rst_rv", 64'(l2_resp_valid_o), 64'h0);
    check_eq("rst_rd", l2_resp_rdata_o, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", 64'(l2_req_ready_o), 64'hF);

    // 1: single read from port 2, response held until accepted
    single_read("t1", 2'd2, 64'h40, 64'hDEAD_BEEF);
    @(negedge clk);
    check_eq("t1_hold_rv", 64'(l2_resp_valid_o), 64'h4);
    check_eq("t1_hold_rd", l2_resp_rdata_o, 64'hDEAD_BEEF);
    l2_resp_ready_i = 4'b0100;
    @(negedge clk);
    check_eq("t1_clr", 64'(l2_resp_valid_o), 64'h0);

    // 2: write then read on port 0
    l2_resp_ready_i = 4'hF;
    base = iss_addr.size();
    set_req(2'd0, 64'h80, 1'b1, 64'h1234);
    @(negedge clk);
    set_req(2'd0, 64'h80, 1'b0, 64'h0);
    @(negedge clk);
    l2_req_valid_i = '0;
    wait_resp("t2_wr", 4'b0001, 64'h0);
    wait_resp("t2_rd", 4'b0001, 64'h1234);
    check_eq("t2_n", 64'(iss_addr.size() - base), 64'd2);
    if (iss_addr.size() >= base + 2) begin
      check_eq("t2_w0", 64'(iss_wr[base]), 64'h1);
      check_eq("t2_w1", 64'(iss_wr[base+1]), 64'h0);
    end

    // 3: fairness with all ports backlogged, from rr pointer 0
    do_reset();
    l2_resp_ready_i = 4'hF;
    base = iss_addr.size();
    for (int p = 0; p < NP; p++) set_req(2'(p), 64'(p * 32'h1000), 1'b0, 64'h0);
    @(negedge clk);
    for (int p = 0; p < NP; p++) set_req(2'(p), 64'(p * 32'h1000 + 8), 1'b0, 64'h0);
    @(negedge clk);
    l2_req_valid_i = '0;
    for (int n = 0; n < 80 && iss_addr.size() < base + 8; n++) @(negedge clk);
    check_eq("t3_n", 64'(iss_addr.size() - base), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (iss_addr.size() > base + k) begin
        check_eq($sformatf("t3_addr%0d", k), iss_addr[base+k], 64'((k % 4) * 32'h1000 + (k / 4) * 8));
        if (k > 0) check_eq($sformatf("t3_gap%0d", k), 64'(iss_cyc[base+k] - iss_cyc[base+k-1]), 64'd4);
      end
    end
    repeat (6) @(negedge clk);

    // 4: FIFO full while arbiter is held in RESP by port 3
    l2_resp_ready_i = 4'b0111;
    set_req(2'd3, 64'h3000, 1'b0, 64'h0);
    @(negedge clk);
    l2_req_valid_i = '0;
    for (int n = 0; n < 20 && l2_resp_valid_o != 4'b1000; n++) @(negedge clk);
    check_eq("t4_held", 64'(l2_resp_valid_o), 64'h8);
    check_eq("t4_rdy_a", 64'(l2_req_ready_o[1]), 64'h1);
    set_req(2'd1, 64'h100, 1'b0, 64'h0);
    @(negedge clk);
    check_eq("t4_rdy_b", 64'(l2_req_ready_o[1]), 64'h1);
    set_req(2'd1, 64'h108, 1'b0, 64'h0);
    @(negedge clk);
    check_eq("t4_rdy_c", 64'(l2_req_ready_o[1]), 64'h0);
    set_req(2'd1, 64'h110, 1'b0, 64'h0);
    @(negedge clk);
    l2_req_valid_i = '0;
    check_eq("t4_rdy_d", 64'(l2_req_ready_o[1]), 64'h0);
    check_eq("t4_still", 64'(l2_resp_valid_o), 64'h8);
    base = iss_addr.size();
    l2_resp_ready_i = 4'hF;
    repeat (30) @(negedge clk);
    check_eq("t4_n", 64'(iss_addr.size() - base), 64'd2);
    if (iss_addr.size() >= base + 2) begin
      check_eq("t4_a0", iss_addr[base], 64'h100);
      check_eq("t4_a1", iss_addr[base+1], 64'h108);
    end
    check_eq("t4_rdy_e", 64'(l2_req_ready_o[1]), 64'h1);

    // 5: spurious slice response in IDLE is ignored
    spur_cnt = spur_cnt + 1;
    seen = '0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      seen = seen | l2_resp_valid_o;
    end
    check_eq("t5_norv", 64'(seen), 64'h0);
    check_eq("t5_rd", l2_resp_rdata_o, 64'h0);
    single_read("t5", 2'd1, 64'h40, 64'hDEAD_BEEF);
    repeat (3) @(negedge clk);

    // 6: reset while waiting on the slice with two requests queued
    slice_hold = 1'b1;
    set_req(2'd0, 64'h40, 1'b0, 64'h0);
    @(negedge clk);
    l2_req_valid_i[0] = 1'b0;
    set_req(2'd1, 64'h1008, 1'b0, 64'h0);
    set_req(2'd2, 64'h2008, 1'b0, 64'h0);
    @(negedge clk);
    l2_req_valid_i = '0;
    check_eq("t6_issue", 64'(l3_req_valid_o), 64'h1);
    @(negedge clk);
    check_eq("t6_wait", 64'(l3_req_valid_o), 64'h0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_ready", 64'(l2_req_ready_o), 64'h0);
    check_eq("t6_addr", l3_req_addr_o, 64'h0);
    check_eq("t6_l3v", 64'(l3_req_valid_o), 64'h0);
    check_eq("t6_rv", 64'(l2_resp_valid_o), 64'h0);
    check_eq("t6_rd", l2_resp_rdata_o, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    slice_hold = 1'b0;
    l2_resp_ready_i = 4'hF;
    base = iss_addr.size();
    seen = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      seen = seen | l2_resp_valid_o;
    end
    check_eq("t6_norv", 64'(seen), 64'h0);
    check_eq("t6_noiss", 64'(iss_addr.size() - base), 64'd0);
    check_eq("t6_empty", 64'(l2_req_ready_o), 64'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
